johnson_slot_arbiter: RTL

JOHNSON_SLOT_ARBITER -- requirements
Module: johnson_slot_arbiter

---
 rtl/johnson_pkg.sv | 37 +++
 rtl/johnson_ring.sv | 32 +++
 rtl/johnson_slot_arbiter.sv | 104 ++++++++++
 3 files changed

// File: rtl/johnson_pkg.sv
// Shared definitions for the Johnson-counter slot arbiter: FSM state encoding,
// the table of legal ring values and the ring-value-to-slot decode.
package johnson_pkg;

    localparam int NUM_SLOTS = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_HOLD  = 2'd2
    } arb_state_e;

    // Ring values in slot order; index i is the value while slot i is current.
    localparam logic [3:0] JOHNSON_TABLE [NUM_SLOTS] = '{
        4'b0000, 4'b0001, 4'b0011, 4'b0111,
        4'b1111, 4'b1110, 4'b1100, 4'b1000
    };

    function automatic logic johnson_is_legal(input logic [3:0] c);
        logic hit;
        hit = 1'b0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            if (c == JOHNSON_TABLE[i]) hit = 1'b1;
        end
        return hit;
    endfunction

    function automatic logic [2:0] johnson_slot(input logic [3:0] c);
        logic [2:0] s;
        s = 3'd0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            if (c == JOHNSON_TABLE[i]) s = 3'(i);
        end
        return s;
    endfunction

endpackage

// File: rtl/johnson_ring.sv
// 4-bit Johnson ring with advance enable; any value outside the eight legal
// codes is pulled back to 0000 on the next edge with a one-cycle err pulse.
module johnson_ring
    import johnson_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       adv,
    output logic [3:0] cnt,
    output logic       err
);

    logic [3:0] cnt_q;
    logic       err_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= 4'b0000;
            err_q <= 1'b0;
        end else if (!johnson_is_legal(cnt_q)) begin
            cnt_q <= 4'b0000;
            err_q <= 1'b1;
        end else begin
            err_q <= 1'b0;
            if (adv) cnt_q <= {cnt_q[2:0], ~cnt_q[3]};
        end
    end

    assign cnt = cnt_q;
    assign err = err_q;

endmodule

// File: rtl/johnson_slot_arbiter.sv
// Eight-way slot arbiter: the slot owner wins first, idle slots may be lent to
// the next requester, and lock can freeze a grant for up to MAX_HOLD cycles.
module johnson_slot_arbiter
    import johnson_pkg::*;
#(
    parameter bit WORK_CONSERVE = 1'b1,
    parameter int MAX_HOLD      = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [7:0] req,
    input  logic       lock,
    output logic [7:0] grant,
    output logic       grant_valid,
    output logic [3:0] cnt,
    output logic [2:0] slot,
    output logic       err
);

    localparam logic [1:0] IDLE      = ST_IDLE;
    localparam logic [1:0] GRANT     = ST_GRANT;
    localparam logic [1:0] HOLD      = ST_HOLD;
    localparam logic [3:0] HOLD_LAST = 4'(MAX_HOLD - 1);

    logic [1:0] state, state_nx;
    logic [7:0] grant_nx, sel;
    logic [3:0] hold_cnt, hold_nx;
    logic       armed, adv, legal, keep;

    johnson_ring u_ring (
        .clk (clk),
        .rst (rst),
        .adv (adv),
        .cnt (cnt),
        .err (err)
    );

    assign legal = johnson_is_legal(cnt);
    assign slot  = johnson_slot(cnt);
    assign keep  = lock && ((req & grant) != 8'h00);

    always_comb begin
        logic       found;
        logic [2:0] idx;
        sel   = 8'h00;
        found = 1'b0;
        idx   = slot;
        if (req[slot]) begin
            sel[slot] = 1'b1;
        end else if (WORK_CONSERVE) begin
            for (int i = 1; i < NUM_SLOTS; i++) begin
                idx = slot + 3'(i);
                if (!found && req[idx]) begin
                    sel[idx] = 1'b1;
                    found    = 1'b1;
                end
            end
        end
    end

    // The first edge after reset only arms the arbiter, so no grant can be
    // decided from the cycle in which reset was released.
    always_comb begin
        state_nx = state;
        grant_nx = grant;
        hold_nx  = hold_cnt;
        adv      = 1'b0;
        if (!legal) begin
            state_nx = IDLE;
            grant_nx = 8'h00;
        end else if (!en || !armed) begin
            state_nx = IDLE;
            grant_nx = 8'h00;
        end else if (state == HOLD && keep && hold_cnt < HOLD_LAST) begin
            hold_nx = hold_cnt + 4'd1;
        end else if (state == GRANT && keep && MAX_HOLD > 1) begin
            state_nx = HOLD;
            hold_nx  = 4'd1;
        end else begin
            adv      = 1'b1;
            grant_nx = sel;
            hold_nx  = 4'd0;
            state_nx = (sel != 8'h00) ? GRANT : IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            grant       <= 8'h00;
            grant_valid <= 1'b0;
            hold_cnt    <= 4'd0;
            armed       <= 1'b0;
        end else begin
            state       <= state_nx;
            grant       <= grant_nx;
            grant_valid <= (grant_nx != 8'h00);
            hold_cnt    <= hold_nx;
            armed       <= 1'b1;
        end
    end

endmodule
